sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Two-requester SRAM access controller for the SLC-3 system. It shares the single off-chip 16-bit SRAM (CE/UB/LB/OE/WE/ADDR/Data) between the CPU memory port and the memory loader/debug port.
- It sequences each access through setup, strobe and completion phases with a parameterised strobe width.
- It grants the SRAM round-robin between the two ports and returns a one-cycle acknowledge with read data.

Parameters:
- WAIT_CYCLES, 2, cycles OE/WE are held low per access; legal range 1..15.
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1=write, 0=read; stable while cpu_req
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data; valid while cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_ack  same as the CPU port, for the loader
- CE, UB, LB, OE, WE  out  1 each  SRAM strobes, active-low
- ADDR  out  ADDR_W  SRAM address
- Data  inout  DATA_W  SRAM data bus, tristated unless writing

Behaviour:
- Reset asserted (Reset=0) acts immediately, not on a clock edge:
  - CE=UB=LB=OE=WE=1, ADDR=0, Data=Z.
  - cpu_ack=ldr_ack=0, cpu_rdata=ldr_rdata=0.
  - state=IDLE, last_grant=LDR, wait counter=0.
- States:
  - IDLE: strobes high, Data Z. If any req is sampled, latch owner, we, addr and wdata, then go to SETUP.
  - SETUP (1 cycle): CE=UB=LB=0, ADDR=latched addr, OE=WE=1. Data is driven with wdata if writing. Go to ACCESS with counter=WAIT_CYCLES-1.
  - ACCESS (WAIT_CYCLES cycles): CE/UB/LB=0. OE=0 for a read, WE=0 for a write. Counter decrements each cycle. On the edge leaving ACCESS with counter=0, a read captures Data into the owner's rdata register. Go to DONE.
  - DONE (1 cycle): CE=UB=LB=OE=WE=1. Owner's ack=1; its rdata stays valid until its next ack. A write keeps Data driven for this cycle as the hold time after WE rises. Go to IDLE.
- Latency:
  - The request is sampled in IDLE at edge k.
  - ack is high in cycle k+2+WAIT_CYCLES (cycle 4 for WAIT_CYCLES=2).
  - The minimum spacing between back-to-back accesses is WAIT_CYCLES+3 cycles; IDLE is always visited.
- Arbitration in IDLE:
  - A single requester wins.
  - If both request, the port opposite last_grant wins.
  - last_grant updates on the grant. After reset the CPU wins the first tie.
  - Neither port waits more than one foreign access.
- The latched owner, we, addr and wdata are frozen from grant through DONE. Input changes mid-access are ignored.
- A req dropped mid-access does not abort the access; ack still pulses once.
- The non-owner's ack is always 0. Both acks are never high in the same cycle.
- A req still high in the IDLE cycle right after its own ack is treated as a new request. Requesters must drop req on ack.
- Reset asserted mid-access releases all strobes and tristates Data immediately with no ack. After Reset=1 the block resumes in IDLE.
- ADDR holds its last value outside SETUP/ACCESS.

Decomposition:
- Package sram_pkg:
  - state enum {IDLE, SETUP, ACCESS, DONE}
  - owner enum {CPU, LDR}
  - localparams for strobe inactive level (1) and default WAIT_CYCLES.
- Sub-module rr_pick2: combinational two-way round-robin pick from (cpu_req, ldr_req, last_grant) to a valid/owner pair. Keeping it separate lets it be reused by the memory-mapped I/O arbiter.
- The FSM, counter, latches and tristate stay in sram_arbiter.

Test Plan:
1. Reset check: hold Reset=0 for 2 cycles with random reqs -> CE=UB=LB=OE=WE=1, ADDR=0, Data=Z, both acks 0 throughout.
2. Single write then read, WAIT_CYCLES=2, behavioural SRAM model:
   - CPU writes 0x1234 to 0x00010 -> SETUP in cycle 1, WE=0 in cycles 2-3, cpu_ack in cycle 4.
   - CPU then reads 0x00010 -> OE=0 for 2 cycles, cpu_rdata=0x1234 with cpu_ack.
3. Simultaneous requests right after reset:
   - CPU read 0x00100 and ldr write 0xBEEF to 0x00200 -> cpu_ack first, ldr_ack exactly 5 cycles later.
   - Raise both again -> CPU served next (alternation).
4. Fairness: hold cpu_req continuously while ldr_req rises -> ldr_ack within 2*(WAIT_CYCLES+3)=10 cycles; acks alternate CPU/LDR for 8 accesses; never both high.
5. Reset during ACCESS of a ldr write -> strobes high and Data=Z immediately, no ldr_ack. After release, a fresh ldr_req completes in WAIT_CYCLES+2 cycles.
6. Rebuild with WAIT_CYCLES=1 -> read ack at cycle 3, OE low exactly 1 cycle. Changing cpu_addr during ACCESS does not change ADDR.

Source files
------------

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and constants for the SLC-3 SRAM arbiter
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } sram_state_e;

    typedef enum logic {
        CPU = 1'b0,
        LDR = 1'b1
    } owner_e;

    localparam logic STROBE_OFF          = 1'b1;
    localparam int   DEFAULT_WAIT_CYCLES = 2;

    function automatic owner_e other_owner(input owner_e o);
        return (o == CPU) ? LDR : CPU;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin pick between CPU and loader
module rr_pick2 import sram_pkg::*; (
    input  logic   cpu_req_i,
    input  logic   ldr_req_i,
    input  owner_e last_grant_i,
    output logic   valid_o,
    output owner_e owner_o
);

    always_comb begin
        valid_o = cpu_req_i | ldr_req_i;
        owner_o = CPU;
        // On a tie the port that did not win last time goes next
        if (cpu_req_i && ldr_req_i) begin
            owner_o = other_owner(last_grant_i);
        end else if (ldr_req_i) begin
            owner_o = LDR;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one async SRAM between the CPU and loader ports
module sram_arbiter import sram_pkg::*; #(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,

    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,

    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] Data
);

    localparam int             CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    sram_state_e       state_q;
    owner_e            owner_q;
    owner_e            last_grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              drive_q;
    logic              ce_q;
    logic              oe_q;
    logic              we_n_q;
    logic              cpu_ack_q;
    logic              ldr_ack_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] ldr_rdata_q;

    logic              pick_valid;
    owner_e            pick_owner;

    rr_pick2 u_pick (
        .cpu_req_i    (cpu_req),
        .ldr_req_i    (ldr_req),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .owner_o      (pick_owner)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            owner_q      <= CPU;
            last_grant_q <= LDR;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            drive_q      <= 1'b0;
            ce_q         <= STROBE_OFF;
            oe_q         <= STROBE_OFF;
            we_n_q       <= STROBE_OFF;
            cpu_ack_q    <= 1'b0;
            ldr_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            cpu_ack_q <= 1'b0;
            ldr_ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        owner_q      <= pick_owner;
                        last_grant_q <= pick_owner;
                        if (pick_owner == LDR) begin
                            we_q    <= ldr_we;
                            addr_q  <= ldr_addr;
                            wdata_q <= ldr_wdata;
                            drive_q <= ldr_we;
                        end else begin
                            we_q    <= cpu_we;
                            addr_q  <= cpu_addr;
                            wdata_q <= cpu_wdata;
                            drive_q <= cpu_we;
                        end
                        ce_q    <= ~STROBE_OFF;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    cnt_q   <= CNT_LOAD;
                    oe_q    <= we_q;
                    we_n_q  <= ~we_q;
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        ce_q    <= STROBE_OFF;
                        oe_q    <= STROBE_OFF;
                        we_n_q  <= STROBE_OFF;
                        state_q <= DONE;
                        // Read data is sampled while OE is still low
                        if (owner_q == LDR) begin
                            ldr_ack_q <= 1'b1;
                            if (!we_q) begin
                                ldr_rdata_q <= Data;
                            end
                        end else begin
                            cpu_ack_q <= 1'b1;
                            if (!we_q) begin
                                cpu_rdata_q <= Data;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    drive_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Write data stays on the bus through DONE to give hold time after WE rises
    assign Data      = drive_q ? wdata_q : {DATA_W{1'bz}};

    assign CE        = ce_q;
    assign UB        = ce_q;
    assign LB        = ce_q;
    assign OE        = oe_q;
    assign WE        = we_n_q;
    assign ADDR      = addr_q;
    assign cpu_ack   = cpu_ack_q;
    assign ldr_ack   = ldr_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ldr_rdata = ldr_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter
module tb_sram_arbiter;

    localparam int          W    = 2;
    localparam logic [15:0] ZBUS = 16'hFFFF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0;
    logic [19:0] cpu_addr = '0, ldr_addr = '0;
    logic [15:0] cpu_wdata = '0, ldr_wdata = '0;
    logic [15:0] cpu_rdata, ldr_rdata;
    logic        cpu_ack, ldr_ack, CE, UB, LB, OE, WE;
    logic [19:0] ADDR;
    tri1  [15:0] Data;

    logic        c1_req = 1'b0, c1_we = 1'b0;
    logic [19:0] c1_addr = '0;
    logic [15:0] c1_rdata, l1_rdata;
    logic        c1_ack, l1_ack, CE1, UB1, LB1, OE1, WE1;
    logic [19:0] ADDR1;
    tri1  [15:0] Data1;

    int checks = 0;
    int passed = 0;

    function automatic logic [15:0] pat(input logic [19:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    sram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(20), .DATA_W(16)) dut (
        .Clk(clk), .Reset(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
        .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .ADDR(ADDR), .Data(Data)
    );

    sram_arbiter #(.WAIT_CYCLES(1), .ADDR_W(20), .DATA_W(16)) dut1 (
        .Clk(clk), .Reset(rst_n),
        .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(16'h0000),
        .cpu_rdata(c1_rdata), .cpu_ack(c1_ack),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(20'h00000), .ldr_wdata(16'h0000),
        .ldr_rdata(l1_rdata), .ldr_ack(l1_ack),
        .CE(CE1), .UB(UB1), .LB(LB1), .OE(OE1), .WE(WE1), .ADDR(ADDR1), .Data(Data1)
    );

    // SRAM devices: unwritten locations read back as pat(addr)
    logic [15:0] sram [1024];
    bit          sram_wr [1024];
    logic [15:0] sram_rd;
    assign sram_rd = sram_wr[ADDR[9:0]] ? sram[ADDR[9:0]] : pat(ADDR);
    assign Data    = (!CE && !OE && WE) ? sram_rd : 16'hzzzz;
    assign Data1   = (!CE1 && !OE1 && WE1) ? pat(ADDR1) : 16'hzzzz;

    always @(negedge clk) begin
        if (!CE && !WE) begin
            sram[ADDR[9:0]]    <= Data;
            sram_wr[ADDR[9:0]] <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Transaction-level model: t counts cycles since the grant edge
    bit          m_busy = 1'b0;
    int          m_t = 0;
    bit          m_owner = 1'b0;
    bit          m_last = 1'b1;
    bit          m_we = 1'b0;
    logic [19:0] m_addr = '0;
    logic [15:0] m_wdata = '0, m_rval = '0;
    logic [15:0] m_rd [2] = '{16'h0, 16'h0};
    logic [15:0] ref_mem [1024];
    bit          ref_wr [1024];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 1'b0; m_t = 0; m_last = 1'b1; m_addr = '0;
            m_rd[0] = '0;  m_rd[1] = '0;
        end else if (m_busy) begin
            if (m_t == W + 1) begin
                if (m_we) begin
                    ref_mem[m_addr[9:0]] = m_wdata;
                    ref_wr[m_addr[9:0]]  = 1'b1;
                end else begin
                    m_rd[m_owner] = m_rval;
                end
            end
            if (m_t == W + 2) m_busy = 1'b0;
            else m_t++;
        end else if (cpu_req || ldr_req) begin
            m_owner = (cpu_req && ldr_req) ? !m_last : ldr_req;
            m_last  = m_owner;
            m_we    = m_owner ? ldr_we    : cpu_we;
            m_addr  = m_owner ? ldr_addr  : cpu_addr;
            m_wdata = m_owner ? ldr_wdata : cpu_wdata;
            m_rval  = ref_wr[m_addr[9:0]] ? ref_mem[m_addr[9:0]] : pat(m_addr);
            m_busy  = 1'b1;
            m_t     = 1;
        end
    end

    initial begin : compare
        logic [4:0]  e_str;
        logic [15:0] e_data;
        logic [1:0]  e_ack;
        forever begin
            @(negedge clk);
            e_str = 5'b11111; e_data = ZBUS; e_ack = 2'b00;
            if (m_busy) begin
                if (m_t <= W + 1) e_str[4:2] = 3'b000;
                if (m_t >= 2 && m_t <= W + 1) begin
                    e_str[1] = m_we;
                    e_str[0] = !m_we;
                end
                if (m_we) e_data = m_wdata;
                else if (m_t >= 2 && m_t <= W + 1) e_data = m_rval;
                if (m_t == W + 2) e_ack = m_owner ? 2'b01 : 2'b10;
            end
            chk("cyc strobes", {CE, UB, LB, OE, WE}, e_str);
            chk("cyc addr", ADDR, m_addr);
            chk("cyc data", Data, e_data);
            chk("cyc acks", {cpu_ack, ldr_ack}, e_ack);
            chk("cyc cpu_rdata", cpu_rdata, m_rd[0]);
            chk("cyc ldr_rdata", ldr_rdata, m_rd[1]);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic access(input bit p, input bit we, input logic [19:0] a, input logic [15:0] d,
                          input int exp_cyc, input int exp_low, input logic [15:0] exp_rd,
                          input string nm);
        int n, low;
        bit got;
        n = 0; low = 0; got = 1'b0;
        if (p) begin ldr_we = we; ldr_addr = a; ldr_wdata = d; ldr_req = 1'b1; end
        else   begin cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; end
        while (!got && n < 20) begin
            tick; n++;
            if (n == 1) chk({nm, " setup"}, {CE, OE, WE}, 3'b011);
            if (we ? !WE : !OE) low++;
            if (p ? ldr_ack : cpu_ack) got = 1'b1;
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        chk({nm, " ack cycle"}, n, exp_cyc);
        chk({nm, " strobe cycles"}, low, exp_low);
        if (!we) chk({nm, " rdata"}, p ? ldr_rdata : cpu_rdata, exp_rd);
        tick;
    endtask

    task automatic both(input bit cwe, input logic [19:0] caddr, input logic [15:0] cwd,
                        input bit lwe, input logic [19:0] laddr, input logic [15:0] lwd,
                        input logic [15:0] c_rd, input logic [15:0] l_rd, input string nm);
        int n, ca, la;
        cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        ldr_we = lwe; ldr_addr = laddr; ldr_wdata = lwd;
        cpu_req = 1'b1; ldr_req = 1'b1;
        n = 0; ca = 0; la = 0;
        while ((ca == 0 || la == 0) && n < 30) begin
            tick; n++;
            if (cpu_ack && ca == 0) begin
                ca = n; cpu_req = 1'b0;
                if (!cwe) chk({nm, " cpu rdata"}, cpu_rdata, c_rd);
            end
            if (ldr_ack && la == 0) begin
                la = n; ldr_req = 1'b0;
                if (!lwe) chk({nm, " ldr rdata"}, ldr_rdata, l_rd);
            end
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        chk({nm, " cpu ack cycle"}, ca, 4);
        chk({nm, " ldr ack cycle"}, la, 9);
        tick;
    endtask

    initial begin : stim
        int n, acks, fl, low;
        bit got;

        for (int i = 0; i < 2; i++) begin
            cpu_req = 1'($urandom_range(0, 1));
            ldr_req = 1'($urandom_range(0, 1));
            tick;
            chk("rst acks", {cpu_ack, ldr_ack}, 2'b00);
            chk("rst strobes", {CE, UB, LB, OE, WE}, 5'b11111);
            chk("rst addr", ADDR, 20'h0);
            chk("rst data", Data, ZBUS);
            chk("rst w1 strobes", {CE1, OE1, WE1, c1_ack}, 4'b1110);
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        #2 rst_n = 1'b1;

        access(1'b0, 1'b1, 20'h00010, 16'h1234, 4, 2, 16'h0000, "cpu write");
        access(1'b0, 1'b0, 20'h00010, 16'h0000, 4, 2, 16'h1234, "cpu read");

        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        both(1'b0, 20'h00100, 16'h0000, 1'b1, 20'h00200, 16'hBEEF, 16'h5B5A, 16'h0000, "tie1");
        both(1'b1, 20'h00010, 16'hCAFE, 1'b0, 20'h00010, 16'h0000, 16'h0000, 16'hCAFE, "tie2");

        cpu_we = 1'b0; cpu_addr = 20'h00010; ldr_we = 1'b0; ldr_addr = 20'h00200;
        cpu_req = 1'b1; n = 0; acks = 0; fl = 0;
        while (acks < 8 && n < 100) begin
            tick; n++;
            if (n == 2) ldr_req = 1'b1;
            if (cpu_ack || ldr_ack) begin
                chk("fair ack order", {cpu_ack, ldr_ack}, (acks % 2 == 0) ? 2'b10 : 2'b01);
                if (ldr_ack && fl == 0) fl = n;
                acks++;
            end
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        chk("fair ack count", acks, 8);
        chk("fair ldr wait", (fl > 0) && (fl - 2 <= 10), 1'b1);
        tick;

        ldr_we = 1'b1; ldr_addr = 20'h00300; ldr_wdata = 16'h7777; ldr_req = 1'b1;
        tick; tick;
        chk("abort in access", {CE, WE}, 2'b00);
        #3 rst_n = 1'b0;
        #1;
        chk("abort strobes", {CE, UB, LB, OE, WE}, 5'b11111);
        chk("abort data", Data, ZBUS);
        chk("abort ack", {cpu_ack, ldr_ack}, 2'b00);
        ldr_req = 1'b0;
        tick;
        chk("abort ack held", {cpu_ack, ldr_ack}, 2'b00);
        #2 rst_n = 1'b1;
        #2;
        access(1'b1, 1'b0, 20'h00200, 16'h0000, 4, 2, 16'hBEEF, "post-abort ldr read");

        c1_we = 1'b0; c1_addr = 20'h00ABC; c1_req = 1'b1;
        n = 0; low = 0; got = 1'b0;
        while (!got && n < 20) begin
            tick; n++;
            if (n == 1) begin
                chk("w1 setup", {CE1, UB1, LB1, OE1}, 4'b0001);
                c1_addr = 20'h0FFFF;
            end
            if (n == 2) chk("w1 addr frozen", ADDR1, 20'h00ABC);
            if (!OE1) low++;
            if (c1_ack) got = 1'b1;
        end
        c1_req = 1'b0;
        chk("w1 ack cycle", n, 3);
        chk("w1 oe cycles", low, 1);
        chk("w1 rdata", c1_rdata, 16'h50E6);
        chk("w1 ldr idle", {l1_ack, l1_rdata}, 17'h0);
        tick; tick;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
